// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

  typedef enum logic [2:0] {IDLE, LEN, DATA, DONE, ERR} loader_state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/inst_loader_byte_assembler.sv
// Packs a byte stream into 32-bit little-endian words; the completed word is
// presented combinationally alongside the strobe of its 4th byte.
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  r_cnt;
  logic [23:0] r_sh;

  // Only the first three bytes need storage; the 4th is taken straight from the input.
  assign word       = {in_byte, r_sh};
  assign word_valid = in_valid && (r_cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
      r_sh  <= '0;
    end else if (clr) begin
      r_cnt <= '0;
      r_sh  <= '0;
    end else if (in_valid) begin
      r_cnt <= r_cnt + 2'd1;
      r_sh  <= {in_byte, r_sh[23:8]};
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Loads a length-prefixed byte stream from the UART into instruction memory
// through its write port, one 32-bit word per write.
module inst_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 15,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       di,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [32:0] CAPACITY = 33'(DEPTH - BASE_ADDR);

  loader_state_t     r_state, w_next;
  logic [31:0]       r_n, r_word_idx, r_di;
  logic [ADDR_W-1:0] r_waddr;
  logic              r_we;
  logic              w_clr, w_load_n, w_write, w_in_valid, w_word_valid;
  logic [31:0]       w_word;

  // Bytes outside LEN/DATA (including one coinciding with start) never reach the assembler.
  assign w_in_valid = rx_valid && ((r_state == LEN) || (r_state == DATA));

  byte_assembler u_asm (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (w_clr),
    .in_valid   (w_in_valid),
    .in_byte    (rx_data),
    .word       (w_word),
    .word_valid (w_word_valid)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_clr    = 1'b0;
    w_load_n = 1'b0;
    w_write  = 1'b0;
    unique case (r_state)
      IDLE, DONE, ERR: begin
        if (start) begin
          w_next = LEN;
          w_clr  = 1'b1;
        end
      end
      LEN: begin
        if (w_word_valid) begin
          w_load_n = 1'b1;
          if (w_word == 32'd0)                 w_next = DONE;
          else if ({1'b0, w_word} > CAPACITY)  w_next = ERR;
          else                                 w_next = DATA;
        end
      end
      DATA: begin
        if (w_word_valid) begin
          w_write = 1'b1;
          if (r_word_idx == r_n - 32'd1) w_next = DONE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_di       <= '0;
      r_n        <= '0;
      r_word_idx <= '0;
    end else begin
      r_we <= w_write;
      if (w_clr) begin
        r_n        <= '0;
        r_word_idx <= '0;
      end
      if (w_load_n) r_n <= w_word;
      if (w_write) begin
        r_di       <= w_word;
        r_waddr    <= ADDR_W'(BASE_ADDR) + r_word_idx[ADDR_W-1:0];
        r_word_idx <= r_word_idx + 32'd1;
      end
    end
  end

  assign we    = r_we;
  assign waddr = r_waddr;
  assign di    = r_di;
  assign busy  = (r_state == LEN) || (r_state == DATA);
  assign done  = (r_state == DONE);
  assign err   = (r_state == ERR);

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: per-cycle vector table plus hand-written
// multi-cycle sequences checked against a log of observed writes.
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        we;
  logic [14:0] waddr;
  logic [31:0] di;
  logic        busy, done, err;

  inst_loader #(.ADDR_W(15), .BASE_ADDR(0), .DEPTH(32768)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .we       (we),
    .waddr    (waddr),
    .di       (di),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic        v;
    logic [7:0]  d;
    logic        we;
    logic [14:0] a;
    logic [31:0] di;
    logic        busy;
    logic        done;
    logic        err;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [14:0] a;
    logic [31:0] d;
    logic        dn;
  } wr_t;

  vec_t tbl[$];
  wr_t  wlog[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (we === 1'b1) wlog.push_back('{cyc, waddr, di, done});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic v, input logic [7:0] d, input logic w,
                     input logic [14:0] a, input logic [31:0] x,
                     input logic b, input logic dn, input logic e);
    vec_t r;
    r.s = s; r.v = v; r.d = d; r.we = w; r.a = a; r.di = x;
    r.busy = b; r.done = dn; r.err = e;
    tbl.push_back(r);
  endtask

  task automatic drive(input logic s, input logic v, input logic [7:0] d);
    @(negedge clk);
    start = s; rx_valid = v; rx_data = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_bytes(input logic [31:0] w);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, w[8*i +: 8]);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"}, {31'd0, we}, 32'd0);
    chk({tag, "_waddr"}, {17'd0, waddr}, 32'd0);
    chk({tag, "_di"}, di, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rstn = 1'b0; start = 1'b0; rx_valid = 1'b0;
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // two-word load with a trailing ignored byte
    add(1,0,8'h00, 0,0,0, 1,0,0);
    add(0,1,8'h02, 0,0,0, 1,0,0);
    add(0,1,8'h00, 0,0,0, 1,0,0);
    add(0,1,8'h00, 0,0,0, 1,0,0);
    add(0,1,8'h00, 0,0,0, 1,0,0);
    add(0,1,8'hEF, 0,0,0, 1,0,0);
    add(0,1,8'hBE, 0,0,0, 1,0,0);
    add(0,1,8'hAD, 0,0,0, 1,0,0);
    add(0,1,8'hDE, 1,0,32'hDEADBEEF, 1,0,0);
    add(0,1,8'h78, 0,0,0, 1,0,0);
    add(0,1,8'h56, 0,0,0, 1,0,0);
    add(0,1,8'h34, 0,0,0, 1,0,0);
    add(0,1,8'h12, 1,1,32'h12345678, 0,1,0);
    add(0,0,8'h00, 0,0,0, 0,1,0);
    add(0,1,8'hAA, 0,0,0, 0,1,0);
    // zero-length load
    add(1,0,8'h00, 0,0,0, 1,0,0);
    add(0,1,8'h00, 0,0,0, 1,0,0);
    add(0,1,8'h00, 0,0,0, 1,0,0);
    add(0,1,8'h00, 0,0,0, 1,0,0);
    add(0,1,8'h00, 0,0,0, 0,1,0);
    add(0,0,8'h00, 0,0,0, 0,1,0);
    // N = 32769 exceeds capacity
    add(1,0,8'h00, 0,0,0, 1,0,0);
    add(0,1,8'h01, 0,0,0, 1,0,0);
    add(0,1,8'h80, 0,0,0, 1,0,0);
    add(0,1,8'h00, 0,0,0, 1,0,0);
    add(0,1,8'h00, 0,0,0, 0,0,1);
    add(0,1,8'h11, 0,0,0, 0,0,1);
    add(0,1,8'h22, 0,0,0, 0,0,1);
    // re-arm clears err, one-word load
    add(1,0,8'h00, 0,0,0, 1,0,0);
    add(0,1,8'h01, 0,0,0, 1,0,0);
    add(0,1,8'h00, 0,0,0, 1,0,0);
    add(0,1,8'h00, 0,0,0, 1,0,0);
    add(0,1,8'h00, 0,0,0, 1,0,0);
    add(0,1,8'h44, 0,0,0, 1,0,0);
    add(0,1,8'h33, 0,0,0, 1,0,0);
    add(0,1,8'h22, 0,0,0, 1,0,0);
    add(0,1,8'h11, 1,0,32'h11223344, 0,1,0);
    // N = 32768 exactly fits: stays busy in DATA
    add(1,0,8'h00, 0,0,0, 1,0,0);
    add(0,1,8'h00, 0,0,0, 1,0,0);
    add(0,1,8'h80, 0,0,0, 1,0,0);
    add(0,1,8'h00, 0,0,0, 1,0,0);
    add(0,1,8'h00, 0,0,0, 1,0,0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst0");
    @(negedge clk);
    rstn = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      start = tbl[i].s; rx_valid = tbl[i].v; rx_data = tbl[i].d;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_we", i), {31'd0, we}, {31'd0, tbl[i].we});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
      chk($sformatf("v%0d_done", i), {31'd0, done}, {31'd0, tbl[i].done});
      chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, tbl[i].err});
      if (tbl[i].we) begin
        chk($sformatf("v%0d_waddr", i), {17'd0, waddr}, {17'd0, tbl[i].a});
        chk($sformatf("v%0d_di", i), di, tbl[i].di);
      end
    end
    idle(1);

    // reset mid-load drops the partial word
    pulse_reset();
    chk_reset_outputs("rst_dat");
    @(negedge clk);
    rstn = 1'b1;
    wlog.delete();
    drive(1'b1, 1'b0, 8'h00);
    send_bytes(32'd1);
    drive(1'b0, 1'b1, 8'hAA);
    drive(1'b0, 1'b1, 8'hBB);
    pulse_reset();
    chk_reset_outputs("rst_mid");
    @(negedge clk);
    rstn = 1'b1;
    drive(1'b1, 1'b0, 8'h00);
    send_bytes(32'd1);
    send_bytes(32'h0A0B0C0D);
    idle(2);
    chk("rst_nwr", wlog.size(), 1);
    if (wlog.size() >= 1) begin
      chk("rst_addr", {17'd0, wlog[0].a}, 32'd0);
      chk("rst_data", wlog[0].d, 32'h0A0B0C0D);
      chk("rst_done", {31'd0, wlog[0].dn}, 32'd1);
    end

    // back-to-back bytes, three words
    wlog.delete();
    drive(1'b1, 1'b0, 8'h00);
    send_bytes(32'd3);
    send_bytes(32'hA0A1A2A3);
    send_bytes(32'hB0B1B2B3);
    send_bytes(32'hC0C1C2C3);
    idle(2);
    chk("b2b_nwr", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("b2b_gap1", wlog[1].cyc - wlog[0].cyc, 4);
      chk("b2b_gap2", wlog[2].cyc - wlog[1].cyc, 4);
      chk("b2b_a0", {17'd0, wlog[0].a}, 32'd0);
      chk("b2b_a1", {17'd0, wlog[1].a}, 32'd1);
      chk("b2b_a2", {17'd0, wlog[2].a}, 32'd2);
      chk("b2b_d0", wlog[0].d, 32'hA0A1A2A3);
      chk("b2b_d2", wlog[2].d, 32'hC0C1C2C3);
      chk("b2b_dn0", {31'd0, wlog[0].dn}, 32'd0);
      chk("b2b_dn2", {31'd0, wlog[2].dn}, 32'd1);
    end

    // bytes in IDLE, byte with start, and start mid-DATA are all ignored
    pulse_reset();
    @(negedge clk);
    rstn = 1'b1;
    wlog.delete();
    send_bytes(32'h88776655);
    #1;
    chk("ign_busy", {31'd0, busy}, 32'd0);
    drive(1'b1, 1'b1, 8'h99);
    send_bytes(32'd2);
    send_bytes(32'h04030201);
    drive(1'b0, 1'b1, 8'h05);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h06);
    drive(1'b0, 1'b1, 8'h07);
    drive(1'b0, 1'b1, 8'h08);
    idle(2);
    chk("ign_nwr", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("ign_a0", {17'd0, wlog[0].a}, 32'd0);
      chk("ign_d0", wlog[0].d, 32'h04030201);
      chk("ign_a1", {17'd0, wlog[1].a}, 32'd1);
      chk("ign_d1", wlog[1].d, 32'h08070605);
      chk("ign_dn1", {31'd0, wlog[1].dn}, 32'd1);
    end
    chk("ign_done", {31'd0, done}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
